// File: rtl/reconstruct_by_msb1_divisor_pkg.sv
// reconstruct_by_msb1_divisor_pkg: state encodings and default widths shared with the divider family
package reconstruct_by_msb1_divisor_pkg;

    typedef enum logic [1:0] {
        ST_READY = 2'd0,
        ST_INITS = 2'd1,
        ST_RUN   = 2'd3
    } state_e;

    localparam int DEF_DIVW = 4;
    localparam int DEF_DVDW = 18;

    function automatic int calc_qw(input int divw, input int dvdw);
        return dvdw - divw + 1;
    endfunction

endpackage

// File: rtl/reconstruct_by_msb1_divisor_shift_add_step.sv
// shift_add_step: one combinational step of an LSB-first shift-add multiply
module shift_add_step #(
    parameter int AW = 20,
    parameter int MW = 4
) (
    input  logic [AW-1:0] acc,
    input  logic [AW-1:0] mcand,
    input  logic [MW-1:0] mplier,
    output logic [AW-1:0] acc_n,
    output logic [AW-1:0] mcand_n,
    output logic [MW-1:0] mplier_n
);

    always_comb begin
        acc_n    = mplier[0] ? acc + mcand : acc;
        mcand_n  = mcand << 1;
        mplier_n = mplier >> 1;
    end

endmodule

// File: rtl/reconstruct_by_msb1_divisor.sv
// reconstruct_by_msb1_divisor: rebuilds quotient*orgdiv+remainder with a fixed-latency shift-add loop
module reconstruct_by_msb1_divisor
    import reconstruct_by_msb1_divisor_pkg::*;
#(
    parameter int DIVW = DEF_DIVW,
    parameter int DVDW = DEF_DVDW,
    parameter int QW   = calc_qw(DIVW, DVDW)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [QW-1:0]   quotient,
    input  logic [DIVW-1:0] orgdiv,
    input  logic [DIVW-1:0] remainder,
    output logic [DVDW-1:0] result,
    output logic            overflow,
    output logic            invalid,
    output logic            result_ready
);

    localparam int AW = DVDW + 2;
    localparam int CW = $clog2(DIVW + 1);

    state_e          state_q, state_d;
    logic [QW-1:0]   quot_q, quot_d;
    logic [DIVW-1:0] div_q, div_d, rem_q, rem_d;
    logic [DIVW-1:0] mplier_q, mplier_d, mplier_n;
    logic [AW-1:0]   acc_q, acc_d, acc_n, mcand_q, mcand_d, mcand_n;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            inv_q, inv_d;
    logic [DVDW-1:0] result_q, result_d;
    logic            overflow_q, overflow_d, invalid_q, invalid_d;

    shift_add_step #(.AW(AW), .MW(DIVW)) u_step (
        .acc      (acc_q),
        .mcand    (mcand_q),
        .mplier   (mplier_q),
        .acc_n    (acc_n),
        .mcand_n  (mcand_n),
        .mplier_n (mplier_n)
    );

    always_comb begin
        state_d    = state_q;
        quot_d     = quot_q;
        div_d      = div_q;
        rem_d      = rem_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        cnt_d      = cnt_q;
        inv_d      = inv_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        invalid_d  = invalid_q;
        if (start) begin
            state_d = ST_INITS;
            quot_d  = quotient;
            div_d   = orgdiv;
            rem_d   = remainder;
        end else begin
            case (state_q)
                ST_INITS: begin
                    acc_d    = {{(AW-DIVW){1'b0}}, rem_q};
                    mcand_d  = {{(AW-QW){1'b0}}, quot_q};
                    mplier_d = div_q;
                    cnt_d    = CW'(DIVW);
                    inv_d    = ~div_q[DIVW-1] | (rem_q >= div_q);
                    state_d  = ST_RUN;
                end
                ST_RUN: begin
                    acc_d    = acc_n;
                    mcand_d  = mcand_n;
                    mplier_d = mplier_n;
                    cnt_d    = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        result_d   = acc_n[DVDW-1:0];
                        overflow_d = |acc_n[AW-1:DVDW];
                        invalid_d  = inv_q;
                        state_d    = ST_READY;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_READY;
            quot_q     <= '0;
            div_q      <= '0;
            rem_q      <= '0;
            acc_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            cnt_q      <= '0;
            inv_q      <= 1'b0;
            result_q   <= '0;
            overflow_q <= 1'b0;
            invalid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            quot_q     <= quot_d;
            div_q      <= div_d;
            rem_q      <= rem_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            cnt_q      <= cnt_d;
            inv_q      <= inv_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
            invalid_q  <= invalid_d;
        end
    end

    assign result       = result_q;
    assign overflow     = overflow_q;
    assign invalid      = invalid_q;
    assign result_ready = (state_q == ST_READY) & ~start;

endmodule

// File: tb/tb_reconstruct_by_msb1_divisor.sv
// tb_reconstruct_by_msb1_divisor: vector table, hand-written corner sequences and random ops against an arithmetic model
module tb_reconstruct_by_msb1_divisor;

    localparam int DIVW = 4;
    localparam int DVDW = 18;
    localparam int QW   = 15;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [QW-1:0]   quotient = '0;
    logic [DIVW-1:0] orgdiv = '0;
    logic [DIVW-1:0] remainder = '0;
    logic [DVDW-1:0] result;
    logic            overflow, invalid, result_ready;

    int passed = 0;
    int total  = 0;

    reconstruct_by_msb1_divisor #(.DIVW(DIVW), .DVDW(DVDW), .QW(QW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .quotient     (quotient),
        .orgdiv       (orgdiv),
        .remainder    (remainder),
        .result       (result),
        .overflow     (overflow),
        .invalid      (invalid),
        .result_ready (result_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    q, d, r;
        int    res;
        bit    ovf, inv;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string n, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", n, act, exp);
    endtask

    function automatic void model(input int q, input int d, input int r,
                                  output int res, output bit ovf, output bit inv);
        longint s;
        s   = longint'(q) * longint'(d) + longint'(r);
        res = int'(s % (longint'(1) << DVDW));
        ovf = s >= (longint'(1) << DVDW);
        inv = (d < (1 << (DIVW - 1))) || (r >= d);
    endfunction

    // Issues one start pulse, scrambles inputs afterwards, and measures edges until result_ready.
    task automatic run_op(input int q, input int d, input int r, output int lat, output bit steady);
        logic [DVDW-1:0] prev;
        @(negedge clk);
        quotient  = QW'(q);
        orgdiv    = DIVW'(d);
        remainder = DIVW'(r);
        start     = 1'b1;
        prev      = result;
        @(posedge clk);
        #1;
        start     = 1'b0;
        quotient  = QW'($urandom);
        orgdiv    = DIVW'($urandom);
        remainder = DIVW'($urandom);
        lat       = 0;
        steady    = 1'b1;
        while (!result_ready && lat < 20) begin
            if (result !== prev) steady = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        int lat, res;
        bit steady, ovf, inv;
        tbl[0] = '{"basic",     5,     13, 7, 72,     1'b0, 1'b0};
        tbl[1] = '{"roundtrip", 18181, 11, 9, 200000, 1'b0, 1'b0};
        tbl[2] = '{"maximum",   32767, 15, 14, 229375, 1'b1, 1'b0};
        tbl[3] = '{"msb0",      3,     6, 1, 19,     1'b0, 1'b1};
        tbl[4] = '{"rem_ge",    1,     8, 8, 16,     1'b0, 1'b1};
        tbl[5] = '{"q_zero",    0,     9, 5, 5,      1'b0, 1'b0};
        tbl[6] = '{"d_zero",    777,   0, 3, 3,      1'b0, 1'b1};

        #1;
        chk("reset_result", result, 0);
        chk("reset_overflow", overflow, 0);
        chk("reset_invalid", invalid, 0);
        chk("reset_ready", result_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            run_op(tbl[i].q, tbl[i].d, tbl[i].r, lat, steady);
            chk({tbl[i].name, "_latency"}, lat, 5);
            chk({tbl[i].name, "_steady"}, steady, 1);
            chk({tbl[i].name, "_result"}, result, tbl[i].res);
            chk({tbl[i].name, "_overflow"}, overflow, tbl[i].ovf);
            chk({tbl[i].name, "_invalid"}, invalid, tbl[i].inv);
        end

        // start held high for several edges stays in init and never signals ready
        @(negedge clk);
        quotient = 15'd2; orgdiv = 4'd9; remainder = 4'd1; start = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("held_start_ready", result_ready, 0);
        end
        start = 1'b0;
        lat = 0;
        while (!result_ready && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("held_start_latency", lat, 5);
        chk("held_start_result", result, 19);

        // restart mid-run: only the second operation completes
        @(negedge clk);
        quotient = 15'd100; orgdiv = 4'd9; remainder = 4'd0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        run_op(2, 15, 3, lat, steady);
        chk("restart_latency", lat, 5);
        chk("restart_steady", steady, 1);
        chk("restart_result", result, 33);
        chk("restart_invalid", invalid, 0);

        // asynchronous reset mid-run clears outputs at once and suppresses completion
        @(negedge clk);
        quotient = 15'd5; orgdiv = 4'd13; remainder = 4'd7; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_result", result, 0);
        chk("midrst_ready", result_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("midrst_no_completion", result, 0);
        chk("midrst_overflow", overflow, 0);

        for (int k = 0; k < 40; k++) begin
            int q, d, r;
            q = int'($urandom_range(0, 32767));
            d = int'($urandom_range(0, 15));
            r = int'($urandom_range(0, 15));
            if (k < 4) q = 32767 - k;
            model(q, d, r, res, ovf, inv);
            run_op(q, d, r, lat, steady);
            chk("rand_latency", lat, 5);
            chk("rand_result", result, res);
            chk("rand_overflow", overflow, ovf);
            chk("rand_invalid", invalid, inv);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/reconstruct_by_msb1_divisor.md
Name: reconstruct_by_msb1_divisor

Overview:
- Inverse of the msb1-divisor remainder/quotient units: rebuilds the dividend as quotient*orgdiv + remainder.
- Uses a multi-cycle shift-add loop with the same start / result_ready handshake as the divider family.
- Sits after a divider, or in a bench, to round-trip check divider outputs. Also serves as the shared multiply-add primitive for modular-arithmetic blocks.
- Flags inputs that no legal divider result could produce.

Parameters:
DIVW, 4, divisor width; orgdiv[DIVW-1] must be 1
DVDW, 18, dividend/result width
QW, DVDW-DIVW+1 (15), quotient width

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request; operands sampled on the edge where start=1
quotient  input  QW  multiplicand
orgdiv  input  DIVW  multiplier (divisor)
remainder  input  DIVW  addend
result  output  DVDW  low DVDW bits of quotient*orgdiv+remainder
overflow  output  1  true sum needs more than DVDW bits
invalid  output  1  orgdiv[DIVW-1]==0 or remainder>=orgdiv
result_ready  output  1  (state==ST_READY) & ~start

Behaviour:
- Reset (rst_n low, asynchronous): state=ST_READY; result=0; overflow=0; invalid=0; internal registers cleared. result_ready is therefore 1 once start is low.
- States (2-bit): ST_READY=0, ST_INITS=1, ST_RUN=3. Encoding is fixed for waveform compatibility with the divider family.
- start=1 on any edge, in any state, forces ST_INITS. A request mid-operation aborts the current one and restarts.
- Operands are captured on the start edge into q_r, d_r, r_r. Later input changes are ignored.
- ST_INITS (1 edge):
  - acc = zero-extended r_r; acc width DVDW+2.
  - mcand = zero-extended q_r; width DVDW+2.
  - mplier = d_r.
  - cnt = DIVW.
  - inv_r = ~d_r[DIVW-1] | (r_r >= d_r), with an unsigned compare.
  - Next state ST_RUN.
- ST_RUN, each edge:
  - if mplier[0], acc += mcand;
  - mcand <<= 1; mplier >>= 1; cnt -= 1.
  - On the edge where cnt==1 (the step is applied first):
    - result = new acc[DVDW-1:0];
    - overflow = |new acc[DVDW+1:DVDW];
    - invalid = inv_r;
    - next state ST_READY.
- Latency: the start edge is edge 0, ST_INITS is edge 1, RUN covers edges 2..DIVW+1. result, overflow and invalid update, and result_ready rises, after edge DIVW+1 (6 cycles for DIVW=4). Latency is fixed and independent of operand values.
- result, overflow and invalid hold their values between operations. They change only on the completing edge, never mid-run.
- The computation completes even when invalid=1; invalid is advisory only.
- Arithmetic:
  - All operands are unsigned. Zero-extend explicitly; no implicit truncation inside acc.
  - Maximum true value is (2^QW-1)*(2^DIVW-1)+(2^DIVW-1), which is below 2^(DVDW+2).
- Boundaries:
  - quotient=0: result=remainder.
  - orgdiv=0: invalid=1, result=remainder.
  - start held high for several cycles: the block stays in ST_INITS and result_ready stays 0.
  - rst_n asserted mid-run: outputs clear immediately; no result is produced.

Decomposition:
- Shared package (intbasic constants): state encodings ST_READY, ST_INITS, ST_RUN.
- The package also carries the default widths DIVW=4 and DVDW=18 and a function computing QW from DIVW and DVDW.
- Natural sub-module shift_add_step: combinational, taking acc, mcand and mplier to next acc, mcand and mplier. It is reusable by a later full multiplier.
- The FSM stays in the top module.

Test Plan:
- Reset with start=0 -> result=0, overflow=0, invalid=0, result_ready=1 before the first clock edge.
- quotient=5, orgdiv=13, remainder=7, one start pulse -> result_ready low for 6 cycles, then result=72, overflow=0, invalid=0.
- Round-trip: quotient=18181, orgdiv=11, remainder=9 -> result=200000 (the divider's dividend), overflow=0, invalid=0.
- Maximum: quotient=32767, orgdiv=15, remainder=14 -> result=229375, overflow=1, invalid=0.
- Illegal inputs:
  - orgdiv=6, remainder=1, quotient=3 -> result=19, invalid=1.
  - quotient=1, orgdiv=8, remainder=8 -> result=16, invalid=1.
- Restart and reset mid-run:
  - Start with q=100, d=9, r=0; 3 cycles later start with q=2, d=15, r=3 -> only one completion, result=33, 6 cycles after the second start.
  - rst_n pulsed low mid-run -> outputs 0 at once, no completion.
